// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and widths for the router port serializer
package router_pkg;

    localparam int ADDR_BITS = 4;
    localparam int DA_W      = 4;
    localparam int BYTE_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PAD,
        ST_DATA,
        ST_STALL,
        ST_GAP
    } serializer_state_e;

    typedef struct packed {
        logic [DA_W-1:0]   da;
        logic              last;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/router_port_serializer_if.sv
// rtl/router_port_serializer_if.sv - byte stream into the serializer
interface router_port_serializer_if;
    import router_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [BYTE_W-1:0] s_data;
    logic              s_last;
    logic [DA_W-1:0]   s_da;

    modport master (output s_valid, s_data, s_last, s_da, input s_ready);
    modport slave  (input s_valid, s_data, s_last, s_da, output s_ready);

endinterface

// File: rtl/router_sync_fifo.sv
// rtl/router_sync_fifo.sv - synchronous FIFO with occupancy count
module router_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_port_serializer.sv
// rtl/router_port_serializer.sv - buffers byte packets and drives the router bit-serial port
module router_port_serializer
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PAD_CYCLES = 5
) (
    input  logic                          clock,
    input  logic                          reset_n,
    router_port_serializer_if.slave       s,
    output logic                          din,
    output logic                          frame_n,
    output logic                          valid_n,
    output logic                          tx_active,
    output logic                          pkt_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PH_MAX = (PAD_CYCLES > ADDR_BITS) ? PAD_CYCLES : ADDR_BITS;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int AIDX_W = $clog2(ADDR_BITS);

    serializer_state_e state, state_d;
    logic [PH_W-1:0]   phase, phase_d;
    logic [2:0]        bit_cnt, bit_d;
    logic [BYTE_W-1:0] shreg, sh_d;
    logic              cur_last, last_d;
    logic [DA_W-1:0]   da_q, da_d;

    fifo_entry_t wr_entry;
    fifo_entry_t head;
    logic        pop;
    logic        full;
    logic        empty;
    logic        din_c, frame_c, valid_c, done_c;

    assign wr_entry  = '{da: s.s_da, last: s.s_last, data: s.s_data};
    assign s.s_ready = !full;

    router_sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (s.s_valid && !full),
        .wdata   (wr_entry),
        .pop     (pop),
        .rdata   (head),
        .count   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_d = state;
        phase_d = phase;
        bit_d   = bit_cnt;
        sh_d    = shreg;
        last_d  = cur_last;
        da_d    = da_q;
        pop     = 1'b0;
        din_c   = 1'b0;
        frame_c = 1'b1;
        valid_c = 1'b1;
        done_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_ADDR;
                    da_d    = head.da;
                    phase_d = '0;
                end
            end
            ST_ADDR: begin
                din_c   = da_q[phase[AIDX_W-1:0]];
                frame_c = 1'b0;
                if (phase == PH_W'(ADDR_BITS - 1)) begin
                    phase_d = '0;
                    state_d = ST_PAD;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            ST_PAD: begin
                din_c   = 1'b1;
                frame_c = 1'b0;
                if (phase == PH_W'(PAD_CYCLES - 1)) begin
                    phase_d = '0;
                    state_d = empty ? ST_STALL : ST_DATA;
                    pop     = !empty;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            ST_DATA: begin
                din_c   = shreg[0];
                frame_c = 1'b0;
                valid_c = 1'b0;
                sh_d    = shreg >> 1;
                bit_d   = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (cur_last) begin
                        frame_c = 1'b1;
                        state_d = ST_GAP;
                    end else if (empty) begin
                        state_d = ST_STALL;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ST_STALL: begin
                din_c   = 1'b1;
                frame_c = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_GAP: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Every pop loads the head byte fresh into the shifter
        if (pop) begin
            sh_d   = head.data;
            last_d = head.last;
            bit_d  = 3'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            phase     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cur_last  <= 1'b0;
            da_q      <= '0;
            din       <= 1'b0;
            frame_n   <= 1'b1;
            valid_n   <= 1'b1;
            tx_active <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            bit_cnt   <= bit_d;
            shreg     <= sh_d;
            cur_last  <= last_d;
            da_q      <= da_d;
            din       <= din_c;
            frame_n   <= frame_c;
            valid_n   <= valid_c;
            tx_active <= (state != ST_IDLE);
            pkt_done  <= done_c;
        end
    end

endmodule

// File: tb/tb_router_port_serializer.sv
// tb/tb_router_port_serializer.sv - directed bench for router_port_serializer
module tb_router_port_serializer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       din, frame_n, valid_n, tx_active, pkt_done;
    logic [4:0] fifo_level;

    router_port_serializer_if sif();

    router_port_serializer #(.FIFO_DEPTH(16), .PAD_CYCLES(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .s          (sif),
        .din        (din),
        .frame_n    (frame_n),
        .valid_n    (valid_n),
        .tx_active  (tx_active),
        .pkt_done   (pkt_done),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    int   nvec = 0;
    int   nerr = 0;
    int   ncyc = 0;
    logic din_l [4096];
    logic fr_l  [4096];
    logic vn_l  [4096];
    logic pd_l  [4096];

    always @(negedge clock) begin
        if (ncyc < 4096) begin
            din_l[ncyc] = din;
            fr_l[ncyc]  = frame_n;
            vn_l[ncyc]  = valid_n;
            pd_l[ncyc]  = pkt_done;
            ncyc = ncyc + 1;
        end
    end

    int         dec_pos, dec_start, dec_end, dec_stalls, dec_err;
    logic [3:0] dec_da;
    logic [7:0] dec_bytes[$];
    logic       saw_full = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [3:0] da, input logic [7:0] d, input logic last);
        int n;
        sif.s_valid = 1'b1;
        sif.s_da    = da;
        sif.s_data  = d;
        sif.s_last  = last;
        for (n = 0; n < 500; n++) begin
            if (fifo_level == 5'd16) begin
                saw_full = 1'b1;
                check("s_ready_at_full", sif.s_ready, 0);
            end
            if (sif.s_ready) break;
            @(negedge clock);
        end
        if (n >= 500) check("push_timeout", n, 0);
        @(negedge clock);
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_done(input int cnt);
        int got = 0;
        int k = 0;
        while (got < cnt && k < 3000) begin
            @(negedge clock);
            k++;
            if (pkt_done) got++;
        end
        check("wait_pkt_done", got, cnt);
        repeat (3) @(negedge clock);
    endtask

    // Protocol decoder over the captured output log
    task automatic decode();
        int         i, bits;
        logic [7:0] cur;
        dec_bytes.delete();
        dec_stalls = 0;
        dec_err    = 0;
        dec_end    = -1;
        cur        = '0;
        i = dec_pos;
        while (i < ncyc && fr_l[i] === 1'b1) i++;
        dec_start = i;
        if (i + 9 >= ncyc) begin
            dec_err++;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            dec_da[k] = din_l[i+k];
            if (vn_l[i+k] !== 1'b1 || fr_l[i+k] !== 1'b0) dec_err++;
        end
        for (int k = 4; k < 9; k++)
            if (din_l[i+k] !== 1'b1 || vn_l[i+k] !== 1'b1 || fr_l[i+k] !== 1'b0) dec_err++;
        i += 9;
        bits = 0;
        while (i < ncyc) begin
            if (vn_l[i] === 1'b0) begin
                cur[bits] = din_l[i];
                bits++;
                if (bits == 8) begin
                    dec_bytes.push_back(cur);
                    bits = 0;
                end
                if (fr_l[i] === 1'b1) begin
                    dec_end = i;
                    break;
                end
            end else if (fr_l[i] === 1'b0 && din_l[i] === 1'b1) begin
                dec_stalls++;
            end else begin
                dec_err++;
                break;
            end
            i++;
        end
        if (dec_end < 0 || bits != 0 || dec_end + 1 >= ncyc) begin
            dec_err++;
        end else begin
            if (pd_l[dec_end+1] !== 1'b1 || fr_l[dec_end+1] !== 1'b1 || vn_l[dec_end+1] !== 1'b1)
                dec_err++;
            dec_pos = dec_end + 1;
        end
    endtask

    logic [16:0] exp_din1 = 17'b1_0100_1011_1111_0011;
    int          end_a;

    initial begin
        reset_n     = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        sif.s_da    = '0;
        repeat (3) @(negedge clock);
        check("rst_outs", {din, frame_n, valid_n}, 3'b011);
        check("rst_ctrl", {sif.s_ready, tx_active, pkt_done}, 3'b100);
        check("rst_level", fifo_level, 0);
        reset_n = 1'b1;

        // 1-byte packet, da=3, data 0xA5, checked cycle by cycle
        push_byte(4'd3, 8'hA5, 1'b1);
        check("t1_idle0_frame", frame_n, 1);
        check("t1_level", fifo_level, 1);
        @(negedge clock);
        check("t1_idle1_frame", frame_n, 1);
        for (int k = 0; k < 17; k++) begin
            @(negedge clock);
            check($sformatf("t1_din_%0d", k), din, exp_din1[k]);
            check($sformatf("t1_fv_%0d", k), {frame_n, valid_n}, {k == 16, k < 9});
        end
        @(negedge clock);
        check("t1_gap", {pkt_done, frame_n, valid_n, din}, 4'b1110);
        @(negedge clock);
        check("t1_after_gap", {pkt_done, tx_active, frame_n}, 3'b001);
        @(posedge clock);
        dec_pos = ncyc;
        @(negedge clock);

        // 3-byte packet, da=15, contiguous payload
        push_byte(4'hF, 8'h01, 1'b0);
        push_byte(4'hF, 8'h80, 1'b0);
        push_byte(4'hF, 8'hFF, 1'b1);
        wait_done(1);
        decode();
        check("t2_err", dec_err, 0);
        check("t2_da", dec_da, 4'hF);
        check("t2_nbytes", dec_bytes.size(), 3);
        check("t2_stalls", dec_stalls, 0);
        if (dec_bytes.size() == 3) begin
            check("t2_b0", dec_bytes[0], 8'h01);
            check("t2_b1", dec_bytes[1], 8'h80);
            check("t2_b2", dec_bytes[2], 8'hFF);
        end

        // Underrun: second byte arrives 10 cycles after first byte's bit 7
        push_byte(4'd6, 8'h3C, 1'b0);
        begin
            int n;
            for (n = 0; n < 100; n++) begin
                if (valid_n === 1'b0) break;
                @(negedge clock);
            end
            check("t3_data_start", n < 100, 1);
        end
        repeat (7) @(negedge clock);
        check("t3_bit7", {valid_n, frame_n}, 2'b00);
        repeat (10) @(negedge clock);
        check("t3_stalling", {din, frame_n, valid_n}, 3'b101);
        push_byte(4'd6, 8'hC3, 1'b1);
        wait_done(1);
        decode();
        check("t3_err", dec_err, 0);
        check("t3_da", dec_da, 4'd6);
        check("t3_stalls", dec_stalls, 12);
        check("t3_nbytes", dec_bytes.size(), 2);
        if (dec_bytes.size() == 2) begin
            check("t3_b0", dec_bytes[0], 8'h3C);
            check("t3_b1", dec_bytes[1], 8'hC3);
        end

        // Full FIFO: 20 bytes of one packet pushed as fast as accepted
        for (int i = 0; i < 20; i++)
            push_byte(4'd9, 8'h10 + 8'(i), i == 19);
        check("t4_saw_full", saw_full, 1);
        wait_done(1);
        decode();
        check("t4_err", dec_err, 0);
        check("t4_da", dec_da, 4'd9);
        check("t4_stalls", dec_stalls, 0);
        check("t4_nbytes", dec_bytes.size(), 20);
        for (int i = 0; i < dec_bytes.size() && i < 20; i++)
            check($sformatf("t4_b%0d", i), dec_bytes[i], 8'h10 + 8'(i));

        // Back-to-back packets, da=1 then da=2
        push_byte(4'd1, 8'h5A, 1'b1);
        push_byte(4'd2, 8'h96, 1'b1);
        wait_done(2);
        decode();
        check("t5a_err", dec_err, 0);
        check("t5a_da", dec_da, 4'd1);
        check("t5a_byte", (dec_bytes.size() == 1) ? 32'(dec_bytes[0]) : 32'hFFFF, 8'h5A);
        end_a = dec_end;
        decode();
        check("t5b_err", dec_err, 0);
        check("t5b_da", dec_da, 4'd2);
        check("t5b_byte", (dec_bytes.size() == 1) ? 32'(dec_bytes[0]) : 32'hFFFF, 8'h96);
        check("t5_spacing", dec_start - end_a, 3);

        // Reset during bit 4 of the first data byte
        push_byte(4'd5, 8'h77, 1'b0);
        push_byte(4'd5, 8'h88, 1'b0);
        push_byte(4'd5, 8'h99, 1'b1);
        begin
            int n;
            for (n = 0; n < 100; n++) begin
                if (valid_n === 1'b0) break;
                @(negedge clock);
            end
            check("t6_data_start", n < 100, 1);
        end
        repeat (4) @(negedge clock);
        check("t6_pre_reset", {frame_n, valid_n, fifo_level}, {2'b00, 5'd2});
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_outs", {din, frame_n, valid_n}, 3'b011);
        check("t6_async_level", fifo_level, 0);
        check("t6_async_ctrl", {sif.s_ready, tx_active, pkt_done}, 3'b100);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        dec_pos = ncyc;
        @(negedge clock);
        push_byte(4'hA, 8'hE1, 1'b1);
        wait_done(1);
        decode();
        check("t6_err", dec_err, 0);
        check("t6_da", dec_da, 4'hA);
        check("t6_byte", (dec_bytes.size() == 1) ? 32'(dec_bytes[0]) : 32'hFFFF, 8'hE1);
        check("t6_level_end", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/router_port_serializer.md
# router_port_serializer

Upstream driver for one router input port. It accepts packets as a byte stream with a per-packet destination address, buffers the bytes in a FIFO, and serializes each packet onto the router's bit-serial input protocol (`din`, `frame_n`, `valid_n`). The protocol is a 4-bit address phase, a 5-cycle pad phase, then the payload LSB-first. Sixteen instances, one per port, feed the router's `din[i]`/`frame_n[i]`/`valid_n[i]`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: byte entries buffered; power of two, ≥2.
- `PAD_CYCLES`, default 5: cycles between the address phase and the data phase.

Ports:
- `clock` in 1: single clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: byte offered.
- `s_ready` out 1: byte accepted when `s_valid && s_ready`.
- `s_data` in 8: payload byte.
- `s_last` in 1: final byte of the packet.
- `s_da` in 4: destination port; meaningful on the first byte of a packet, stored with every byte.
- `din` out 1: serial bit to the router input port.
- `frame_n` out 1: low for the duration of a packet, high on its final data bit.
- `valid_n` out 1: low when `din` carries a payload bit.
- `tx_active` out 1: high while the FSM is not in IDLE.
- `pkt_done` out 1: one-cycle pulse in the GAP cycle after each packet.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current entry count.

## Operation
- FIFO entry format: {da[3:0], last, data[7:0]} (13 bits).
- Push condition: `s_valid && s_ready`.
- `s_ready` = !full. There is no pass-through when full, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: `din`=0, `frame_n`=1, `valid_n`=1. Leave for ADDR when the FIFO is non-empty; latch the head entry's da.
  - ADDR: 4 cycles, `din`=da[0..3] LSB first, `frame_n`=0, `valid_n`=1.
  - PAD: PAD_CYCLES cycles, `din`=1, `frame_n`=0, `valid_n`=1. On the last PAD cycle, pop the head into the 8-bit shift register. If the FIFO is empty, go to STALL instead.
  - DATA: 8 cycles per byte, LSB first, `valid_n`=0, `frame_n`=0. On bit 7:
    - If the byte is marked last, drive `frame_n`=1 in that cycle, then go to GAP.
    - Otherwise, pop the next entry if the FIFO is non-empty and continue in DATA; if empty, go to STALL.
  - STALL: `din`=1, `valid_n`=1, `frame_n`=0. Stall cycles are not payload. Leave for DATA when the FIFO is non-empty; the pop happens on the exit cycle.
  - GAP: exactly 1 cycle, `din`=0, `frame_n`=1, `valid_n`=1, `pkt_done`=1. Then go to IDLE; the next packet may start the following cycle.
- The da of bytes other than a packet's first byte is ignored.
- Every packet has at least one byte; `s_last` on the first byte means a 1-byte packet.
- Bit counter: 3 bits for DATA; a phase counter covers ADDR and PAD.

## Timing
- All outputs are registered.
- Reset values:
  - `din`=0, `frame_n`=1, `valid_n`=1.
  - `s_ready`=1, `tx_active`=0, `pkt_done`=0, `fifo_level`=0.
  - FSM in IDLE, FIFO empty.
- Latency: a byte accepted at edge E into an empty, idle block puts the first address bit on `din` after edge E+2.
- Uninterrupted N-byte packet: `frame_n` low for 4+PAD_CYCLES+8N−1 cycles, high on the last data bit. For N=1 that is 16 low cycles plus 1 high.
- Back-to-back packets: exactly one GAP cycle plus one IDLE cycle between them.
- Simultaneous push and pop on a non-full FIFO: both occur and the level is unchanged.
- Pointer wrap-around is modulo FIFO_DEPTH; a separate count register distinguishes full from empty.
- `reset_n` asserted mid-packet:
  - Outputs return to their reset values immediately (asynchronously).
  - FIFO is flushed; the partial packet is abandoned.
  - The router sees `frame_n` rise with `valid_n` high.

## Structure
- `router_pkg`:
  - `serializer_state_e` enum.
  - `ADDR_BITS`=4, `DA_W`=4, `BYTE_W`=8.
  - Packed struct `fifo_entry_t` {da, last, data}.
- Sub-module: `router_sync_fifo`, a parameterized synchronous FIFO with width, depth, count, full and empty outputs. Asynchronous active-low reset on `clock`/`reset_n`.
- Top level holds the FSM, shift register and counters.

## Test plan
- 1-byte packet, da=3, data=0xA5:
  - `din` address bits 1,1,0,0, then 5 pad cycles of 1.
  - Then data bits 1,0,1,0,0,1,0,1 with `valid_n`=0.
  - `frame_n` rises on the 8th data bit; `pkt_done` pulses one cycle later.
- 3-byte packet, da=15, data 0x01,0x80,0xFF pushed in consecutive cycles: 24 contiguous `valid_n`=0 cycles with no STALL, and `frame_n` high only on the last.
- Underrun: byte 2 of a 2-byte packet delayed 10 cycles past byte 1's bit 7:
  - STALL cycles with `valid_n`=1, `frame_n`=0, `din`=1 until the byte is available.
  - Byte 2 payload follows intact.
- Full FIFO: push 20 bytes of one packet in consecutive cycles while the block is in ADDR:
  - `s_ready` drops at `fifo_level`=16.
  - No byte lost or duplicated; serialized order equals pushed order.
- Back-to-back packets, da=1 then da=2: exactly one GAP and one IDLE cycle between packets, and the second address phase carries 0,1,0,0.
- Reset asserted during bit 4 of DATA: outputs go to `din`=0/`frame_n`=1/`valid_n`=1 without waiting for a clock edge, `fifo_level`=0, and a new packet after release serializes correctly.
